// File: rtl/stack_unit.sv
// stack_unit: dual hardware stack (data + return) for the Forth core.
// Each stack supports push/pop/replace every cycle; i_XFER moves a cell
// between the stacks atomically. TOS/NOS/RTOS are masked to zero when the
// corresponding entries do not exist. Error flags are sticky.
// Optional build macro STACK_UNIT_WRAP_EN: when defined, a push into a full
// stack overwrites the oldest cell (circular stack) instead of being dropped.
module stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_CLOCK,
  input  logic             i_RESET,
  input  logic [1:0]       i_DOP,
  input  logic [WIDTH-1:0] i_DDATA,
  input  logic [1:0]       i_ROP,
  input  logic [WIDTH-1:0] i_RDATA,
  input  logic [1:0]       i_XFER,
  input  logic             i_CLRERR,
  output logic [WIDTH-1:0] o_TOS,
  output logic [WIDTH-1:0] o_NOS,
  output logic [WIDTH-1:0] o_RTOS,
  output logic [AW:0]      o_DDEPTH,
  output logic [AW:0]      o_RDEPTH,
  output logic             f_DOVF,
  output logic             f_DUNF,
  output logic             f_ROVF,
  output logic             f_RUNF
);

`ifdef STACK_UNIT_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [1:0]    OP_PUSH = 2'b01;
  localparam logic [1:0]    OP_POP  = 2'b10;
  localparam logic [1:0]    OP_REPL = 2'b11;
  localparam logic [1:0]    XF_D2R  = 2'b01;
  localparam logic [1:0]    XF_R2D  = 2'b10;
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ONE     = 1;
  localparam logic [AW-1:0] TWO     = 2;

  logic [WIDTH-1:0] dMem_q [DEPTH];
  logic [WIDTH-1:0] rMem_q [DEPTH];
  logic [AW-1:0]    dPtr_q, dPtr_d, rPtr_q, rPtr_d;
  logic [AW:0]      dCnt_q, dCnt_d, rCnt_q, rCnt_d;
  logic             dOvf_q, dUnf_q, rOvf_q, rUnf_q;

  logic             dEmpty, dFull, rEmpty, rFull;
  logic [WIDTH-1:0] dTosRaw, dNosRaw, rTosRaw;
  logic             dPush, dPop, dRepl, rPush, rPop, rRepl;
  logic [WIDTH-1:0] dWData, rWData;
  logic             setDOvf, setDUnf, setROvf, setRUnf;

  assign dEmpty  = (dCnt_q == '0);
  assign rEmpty  = (rCnt_q == '0);
  assign dFull   = (dCnt_q == FULL);
  assign rFull   = (rCnt_q == FULL);
  assign dTosRaw = dMem_q[dPtr_q - ONE];
  assign dNosRaw = dMem_q[dPtr_q - TWO];
  assign rTosRaw = rMem_q[rPtr_q - ONE];

  // Decode the requested operations into legal per-stack actions and error events
  always_comb begin
    dPush   = 1'b0;
    dPop    = 1'b0;
    dRepl   = 1'b0;
    rPush   = 1'b0;
    rPop    = 1'b0;
    rRepl   = 1'b0;
    dWData  = i_DDATA;
    rWData  = i_RDATA;
    setDOvf = 1'b0;
    setDUnf = 1'b0;
    setROvf = 1'b0;
    setRUnf = 1'b0;
    if (i_XFER == XF_D2R) begin
      setDUnf = dEmpty;
      setROvf = rFull;
      if (!dEmpty && (!rFull || WRAP_EN)) begin
        dPop   = 1'b1;
        rPush  = 1'b1;
        rWData = dTosRaw;
      end
    end else if (i_XFER == XF_R2D) begin
      setRUnf = rEmpty;
      setDOvf = dFull;
      if (!rEmpty && (!dFull || WRAP_EN)) begin
        rPop   = 1'b1;
        dPush  = 1'b1;
        dWData = rTosRaw;
      end
    end else begin
      case (i_DOP)
        OP_PUSH: begin
          setDOvf = dFull;
          dPush   = !dFull || WRAP_EN;
        end
        OP_POP: begin
          setDUnf = dEmpty;
          dPop    = !dEmpty;
        end
        OP_REPL: begin
          setDUnf = dEmpty;
          dRepl   = !dEmpty;
        end
        default: ;
      endcase
      case (i_ROP)
        OP_PUSH: begin
          setROvf = rFull;
          rPush   = !rFull || WRAP_EN;
        end
        OP_POP: begin
          setRUnf = rEmpty;
          rPop    = !rEmpty;
        end
        OP_REPL: begin
          setRUnf = rEmpty;
          rRepl   = !rEmpty;
        end
        default: ;
      endcase
    end
  end

  // Next pointer and clamped occupancy for both stacks
  always_comb begin
    dPtr_d = dPtr_q;
    dCnt_d = dCnt_q;
    rPtr_d = rPtr_q;
    rCnt_d = rCnt_q;
    if (dPush) begin
      dPtr_d = dPtr_q + ONE;
      if (!dFull) dCnt_d = dCnt_q + 1'b1;
    end else if (dPop) begin
      dPtr_d = dPtr_q - ONE;
      dCnt_d = dCnt_q - 1'b1;
    end
    if (rPush) begin
      rPtr_d = rPtr_q + ONE;
      if (!rFull) rCnt_d = rCnt_q + 1'b1;
    end else if (rPop) begin
      rPtr_d = rPtr_q - ONE;
      rCnt_d = rCnt_q - 1'b1;
    end
  end

  // Pointers, counts and sticky flags; flag setting wins over a same-cycle clear
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      dPtr_q <= '0;
      dCnt_q <= '0;
      rPtr_q <= '0;
      rCnt_q <= '0;
      dOvf_q <= 1'b0;
      dUnf_q <= 1'b0;
      rOvf_q <= 1'b0;
      rUnf_q <= 1'b0;
    end else begin
      dPtr_q <= dPtr_d;
      dCnt_q <= dCnt_d;
      rPtr_q <= rPtr_d;
      rCnt_q <= rCnt_d;
      dOvf_q <= setDOvf | (dOvf_q & ~i_CLRERR);
      dUnf_q <= setDUnf | (dUnf_q & ~i_CLRERR);
      rOvf_q <= setROvf | (rOvf_q & ~i_CLRERR);
      rUnf_q <= setRUnf | (rUnf_q & ~i_CLRERR);
    end
  end

  // Cell storage is never cleared; writes are suppressed while reset is asserted
  always_ff @(posedge i_CLOCK) begin
    if (!i_RESET) begin
      if (dPush) dMem_q[dPtr_q] <= dWData;
      else if (dRepl) dMem_q[dPtr_q - ONE] <= dWData;
      if (rPush) rMem_q[rPtr_q] <= rWData;
      else if (rRepl) rMem_q[rPtr_q - ONE] <= rWData;
    end
  end

  assign o_TOS    = dEmpty ? '0 : dTosRaw;
  assign o_NOS    = (dCnt_q < 2) ? '0 : dNosRaw;
  assign o_RTOS   = rEmpty ? '0 : rTosRaw;
  assign o_DDEPTH = dCnt_q;
  assign o_RDEPTH = rCnt_q;
  assign f_DOVF   = dOvf_q;
  assign f_DUNF   = dUnf_q;
  assign f_ROVF   = rOvf_q;
  assign f_RUNF   = rUnf_q;

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: table-driven bench for stack_unit with DEPTH=4. Each applied
// vector pushes its expected outputs onto a scoreboard queue; after the clock
// edge the front entry is popped and compared field by field.
module tb_stack_unit;

  localparam int W = 16;
  localparam int D = 4;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] dop;
    logic [15:0] ddata;
    logic [1:0] rop;
    logic [15:0] rdata;
    logic [1:0] xfer;
    logic       clr;
    logic [15:0] tos;
    logic [15:0] nos;
    logic [15:0] rtos;
    logic [2:0] dd;
    logic [2:0] rd;
    logic [3:0] fl;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  dop, rop, xfer;
  logic [15:0] ddata, rdata;
  logic        clrerr;
  logic [15:0] tos, nos, rtos;
  logic [2:0]  ddepth, rdepth;
  logic        dovf, dunf, rovf, runf;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   passes = 0;

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .i_CLOCK (clock),
    .i_RESET (reset),
    .i_DOP   (dop),
    .i_DDATA (ddata),
    .i_ROP   (rop),
    .i_RDATA (rdata),
    .i_XFER  (xfer),
    .i_CLRERR(clrerr),
    .o_TOS   (tos),
    .o_NOS   (nos),
    .o_RTOS  (rtos),
    .o_DDEPTH(ddepth),
    .o_RDEPTH(rdepth),
    .f_DOVF  (dovf),
    .f_DUNF  (dunf),
    .f_ROVF  (rovf),
    .f_RUNF  (runf)
  );

  // Free-running clock
  always #5 clock = ~clock;

  function automatic vec_t mk(string name, logic rst, logic [1:0] dopV, logic [15:0] dd,
                              logic [1:0] ropV, logic [15:0] rdd, logic [1:0] xf, logic clr,
                              logic [15:0] eTos, logic [15:0] eNos, logic [15:0] eRtos,
                              logic [2:0] eDd, logic [2:0] eRd, logic [3:0] eFl);
    vec_t v;
    v.name = name; v.rst = rst; v.dop = dopV; v.ddata = dd; v.rop = ropV; v.rdata = rdd;
    v.xfer = xf; v.clr = clr; v.tos = eTos; v.nos = eNos; v.rtos = eRtos;
    v.dd = eDd; v.rd = eRd; v.fl = eFl;
    return v;
  endfunction

  task automatic checkField(string nm, string fld, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    else passes++;
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard empty actual=0 expected=1 entries");
      return;
    end
    e = sb.pop_front();
    checkField(e.name, "tos", tos, e.tos);
    checkField(e.name, "nos", nos, e.nos);
    checkField(e.name, "rtos", rtos, e.rtos);
    checkField(e.name, "ddepth", 16'(ddepth), 16'(e.dd));
    checkField(e.name, "rdepth", 16'(rdepth), 16'(e.rd));
    checkField(e.name, "flags", 16'({dovf, dunf, rovf, runf}), 16'(e.fl));
  endtask

  task automatic applyStimulus(vec_t v);
    reset = v.rst; dop = v.dop; ddata = v.ddata; rop = v.rop;
    rdata = v.rdata; xfer = v.xfer; clrerr = v.clr;
    sb.push_back(v);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [15:0] expTos;
    reset = 1'b1; dop = 2'b00; rop = 2'b00; xfer = 2'b00;
    ddata = '0; rdata = '0; clrerr = 1'b0;
    @(negedge clock);

    //          name          rst dop   ddata     rop   rdata    xf    clr tos      nos      rtos     dd rd fl
    tbl.push_back(mk("reset0",   1, 2'd0, 16'h0,    2'd0, 16'h0,   2'd0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 4'b0000));
    tbl.push_back(mk("push1",    0, 2'd1, 16'h1111, 2'd0, 16'h0,   2'd0, 0, 16'h1111, 16'h0,    16'h0,    1, 0, 4'b0000));
    tbl.push_back(mk("push2",    0, 2'd1, 16'h2222, 2'd0, 16'h0,   2'd0, 0, 16'h2222, 16'h1111, 16'h0,    2, 0, 4'b0000));
    tbl.push_back(mk("push3",    0, 2'd1, 16'h3333, 2'd0, 16'h0,   2'd0, 0, 16'h3333, 16'h2222, 16'h0,    3, 0, 4'b0000));
    tbl.push_back(mk("pop1",     0, 2'd2, 16'h0,    2'd0, 16'h0,   2'd0, 0, 16'h2222, 16'h1111, 16'h0,    2, 0, 4'b0000));
    tbl.push_back(mk("reset1",   1, 2'd0, 16'h0,    2'd0, 16'h0,   2'd0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 4'b0000));
    tbl.push_back(mk("pushA",    0, 2'd1, 16'hAAAA, 2'd0, 16'h0,   2'd0, 0, 16'hAAAA, 16'h0,    16'h0,    1, 0, 4'b0000));
    tbl.push_back(mk("pushB",    0, 2'd1, 16'hBBBB, 2'd0, 16'h0,   2'd0, 0, 16'hBBBB, 16'hAAAA, 16'h0,    2, 0, 4'b0000));
    tbl.push_back(mk("xferD2R",  0, 2'd0, 16'h0,    2'd0, 16'h0,   2'd1, 0, 16'hAAAA, 16'h0,    16'hBBBB, 1, 1, 4'b0000));
    tbl.push_back(mk("xferR2D",  0, 2'd1, 16'h1234, 2'd0, 16'h0,   2'd2, 0, 16'hBBBB, 16'hAAAA, 16'h0,    2, 0, 4'b0000));
    tbl.push_back(mk("rPopEmpty",0, 2'd0, 16'h0,    2'd2, 16'h0,   2'd0, 0, 16'hBBBB, 16'hAAAA, 16'h0,    2, 0, 4'b0001));
    tbl.push_back(mk("clr1",     0, 2'd0, 16'h0,    2'd0, 16'h0,   2'd0, 1, 16'hBBBB, 16'hAAAA, 16'h0,    2, 0, 4'b0000));
    tbl.push_back(mk("reset2",   1, 2'd1, 16'h5A5A, 2'd1, 16'h5A5A,2'd0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 4'b0000));
    tbl.push_back(mk("xferDEmp", 0, 2'd0, 16'h0,    2'd0, 16'h0,   2'd1, 0, 16'h0,    16'h0,    16'h0,    0, 0, 4'b0100));
    tbl.push_back(mk("clr2",     0, 2'd0, 16'h0,    2'd0, 16'h0,   2'd0, 1, 16'h0,    16'h0,    16'h0,    0, 0, 4'b0000));
    tbl.push_back(mk("rPush",    0, 2'd0, 16'h0,    2'd1, 16'h0011,2'd0, 0, 16'h0,    16'h0,    16'h0011, 0, 1, 4'b0000));
    tbl.push_back(mk("simul",    0, 2'd1, 16'h0042, 2'd3, 16'h00FF,2'd0, 0, 16'h0042, 16'h0,    16'h00FF, 1, 1, 4'b0000));
    tbl.push_back(mk("dRepl",    0, 2'd3, 16'h0077, 2'd0, 16'h0,   2'd0, 0, 16'h0077, 16'h0,    16'h00FF, 1, 1, 4'b0000));
    tbl.push_back(mk("rPop",     0, 2'd0, 16'h0,    2'd2, 16'h0,   2'd0, 0, 16'h0077, 16'h0,    16'h0,    1, 0, 4'b0000));
    tbl.push_back(mk("clrSetWin",0, 2'd0, 16'h0,    2'd2, 16'h0,   2'd0, 1, 16'h0077, 16'h0,    16'h0,    1, 0, 4'b0001));
    tbl.push_back(mk("sticky",   0, 2'd1, 16'h5555, 2'd0, 16'h0,   2'd0, 0, 16'h5555, 16'h0077, 16'h0,    2, 0, 4'b0001));
    tbl.push_back(mk("rstMid",   1, 2'd1, 16'h7777, 2'd0, 16'h0,   2'd0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 4'b0000));
    tbl.push_back(mk("dReplEmp", 0, 2'd3, 16'h1234, 2'd0, 16'h0,   2'd0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 4'b0100));
    tbl.push_back(mk("xferREmp", 0, 2'd0, 16'h0,    2'd0, 16'h0,   2'd2, 0, 16'h0,    16'h0,    16'h0,    0, 0, 4'b0101));

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Overflow sequence: push 1..5 into a 4-deep data stack
    applyStimulus(mk("ovfRst", 1, 2'd0, 16'h0, 2'd0, 16'h0, 2'd0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 4'b0000));
    applyStimulus(mk("ovfP1", 0, 2'd1, 16'd1, 2'd0, 16'h0, 2'd0, 0, 16'd1, 16'd0, 16'h0, 1, 0, 4'b0000));
    applyStimulus(mk("ovfP2", 0, 2'd1, 16'd2, 2'd0, 16'h0, 2'd0, 0, 16'd2, 16'd1, 16'h0, 2, 0, 4'b0000));
    applyStimulus(mk("ovfP3", 0, 2'd1, 16'd3, 2'd0, 16'h0, 2'd0, 0, 16'd3, 16'd2, 16'h0, 3, 0, 4'b0000));
    applyStimulus(mk("ovfP4", 0, 2'd1, 16'd4, 2'd0, 16'h0, 2'd0, 0, 16'd4, 16'd3, 16'h0, 4, 0, 4'b0000));
`ifdef STACK_UNIT_WRAP_EN
    applyStimulus(mk("ovfP5", 0, 2'd1, 16'd5, 2'd0, 16'h0, 2'd0, 0, 16'd5, 16'd4, 16'h0, 4, 0, 4'b1000));
    expTos = 16'd5;
`else
    applyStimulus(mk("ovfP5", 0, 2'd1, 16'd5, 2'd0, 16'h0, 2'd0, 0, 16'd4, 16'd3, 16'h0, 4, 0, 4'b1000));
    expTos = 16'd4;
`endif
    // Drain: each pop exposes the next older cell; the last pops to empty
    for (int k = 1; k <= 4; k++) begin
      logic [15:0] t, n;
      t = (k == 4) ? 16'h0 : expTos - 16'(k);
      n = (k >= 3) ? 16'h0 : expTos - 16'(k) - 16'd1;
      applyStimulus(mk($sformatf("ovfPop%0d", k), 0, 2'd2, 16'h0, 2'd0, 16'h0, 2'd0, 0,
                       t, n, 16'h0, 3'(4 - k), 0, 4'b1000));
    end
    applyStimulus(mk("ovfPopEmp", 0, 2'd2, 16'h0, 2'd0, 16'h0, 2'd0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 4'b1100));

    // Transfer into a full return stack
    applyStimulus(mk("xfRst", 1, 2'd0, 16'h0, 2'd0, 16'h0, 2'd0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 4'b0000));
    for (int k = 1; k <= 4; k++)
      applyStimulus(mk($sformatf("xfR%0d", k), 0, 2'd0, 16'h0, 2'd1, 16'(k * 16), 2'd0, 0,
                       16'h0, 16'h0, 16'(k * 16), 0, 3'(k), 4'b0000));
    applyStimulus(mk("xfD", 0, 2'd1, 16'h0099, 2'd0, 16'h0, 2'd0, 0, 16'h0099, 16'h0, 16'h0040, 1, 4, 4'b0000));
`ifdef STACK_UNIT_WRAP_EN
    applyStimulus(mk("xfFull", 0, 2'd0, 16'h0, 2'd0, 16'h0, 2'd1, 0, 16'h0, 16'h0, 16'h0099, 0, 4, 4'b0010));
`else
    applyStimulus(mk("xfFull", 0, 2'd0, 16'h0, 2'd0, 16'h0, 2'd1, 0, 16'h0099, 16'h0, 16'h0040, 1, 4, 4'b0010));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Parametrised dual hardware stack (data stack and return stack) for the Forth core, replacing the pointer-in-register-bank plus main-memory stack scheme. Each stack has an independent push, pop or replace operation every cycle, and single-cycle transfers move values between the two stacks. The unit exposes top-of-stack and next-on-stack directly as ALU operands, plus depth counters and sticky error flags. It sits beside the register bank and is driven by the control unit.

## Interface

Parameters:
- `WIDTH`, default 16: cell width in bits.
- `DEPTH`, default 16: cells per stack; must be a power of two, at least 4.
- `AW`, default `$clog2(DEPTH)`: index width. Derived; do not override.

Ports:
- `i_CLOCK`, in, 1: the single clock; all state updates on its rising edge.
- `i_RESET`, in, 1: synchronous, active-high reset.
- `i_DOP`, in, 2: data-stack op. 00 nop, 01 push, 10 pop, 11 replace (overwrite TOS).
- `i_DDATA`, in, WIDTH: data-stack push/replace value.
- `i_ROP`, in, 2: return-stack op, same encoding as `i_DOP`.
- `i_RDATA`, in, WIDTH: return-stack push/replace value.
- `i_XFER`, in, 2: 00 none, 01 D→R (`>R`), 10 R→D (`R>`), 11 reserved (treated as none).
- `i_CLRERR`, in, 1: clears all sticky error flags.
- `o_TOS`, out, WIDTH: data-stack top.
- `o_NOS`, out, WIDTH: data-stack second entry.
- `o_RTOS`, out, WIDTH: return-stack top.
- `o_DDEPTH`, out, AW+1: data-stack occupancy, 0..DEPTH.
- `o_RDEPTH`, out, AW+1: return-stack occupancy, 0..DEPTH.
- `f_DOVF`, `f_DUNF`, `f_ROVF`, `f_RUNF`, out, 1 each: sticky overflow/underflow flags.

## Operation

- Each stack is a DEPTH×WIDTH flop array with a write pointer `ptr` (AW bits) and a count (AW+1 bits). TOS is at `ptr-1` and NOS at `ptr-2`, mod DEPTH.
- **Push:** writes `mem[ptr]`, then `ptr+1` and `count+1`.
- **Pop:** `ptr-1`, `count-1`. Array contents are untouched.
- **Replace:** writes `mem[ptr-1]`; pointer and count are unchanged.
- **`i_XFER` != 00** overrides both `i_DOP` and `i_ROP`.
  - D→R pops data and pushes the old data TOS onto return.
  - R→D pops return and pushes the old return TOS onto data.
  - Transfers are atomic: if either half is illegal, neither stack changes, and the offending flag(s) are set.
- **Illegal ops:**
  - Pop or replace with count 0: no state change, set UNF.
  - Push with count DEPTH: behaviour is set by Configuration.
- **Output masking:**
  - `o_TOS` = 0 when `o_DDEPTH` = 0.
  - `o_NOS` = 0 when `o_DDEPTH` < 2.
  - `o_RTOS` = 0 when `o_RDEPTH` = 0.
- **Flags:** sticky until `i_CLRERR` or reset. If `i_CLRERR` and a new error occur in the same cycle, the flag ends up set (set wins).
- **Reset:** `ptr`, count and all flags go to 0, so every output reads 0. Array contents are not reset. Reset overrides any op in the same cycle, including one in progress.

## Timing

- All outputs are combinational from registered state only; there is no input-to-output combinational path.
- Latency is one cycle: an op sampled at edge N is visible on the outputs immediately after edge N.
- Back-to-back ops are allowed every cycle with no stall or handshake.
- Simultaneous `i_DOP` and `i_ROP` act independently in the same cycle.
- Pointer arithmetic wraps mod DEPTH.
- Count arithmetic never wraps: it is clamped to the range 0..DEPTH.

## Configuration

- Macro: `STACK_UNIT_WRAP_EN`.
- **Defined:** each stack is circular. A push at count DEPTH writes `mem[ptr]` (overwriting the oldest cell), advances `ptr`, holds count at DEPTH and sets OVF. A D→R or R→D transfer into a full destination proceeds under the same rule.
- **Undefined:** a push at count DEPTH is dropped with no state change and sets OVF. A transfer into a full destination is dropped atomically and sets the destination's OVF.
- Underflow behaviour is identical in both builds.

## Test plan

- **Reset and basic order:** reset, then push 0x1111, 0x2222, 0x3333 on data → `o_TOS`=0x3333, `o_NOS`=0x2222, `o_DDEPTH`=3. Pop → `o_TOS`=0x2222, `o_DDEPTH`=2.
- **Transfer:** data holds 0xAAAA, 0xBBBB; `i_XFER`=01 → `o_RTOS`=0xBBBB, `o_RDEPTH`=1, `o_TOS`=0xAAAA, `o_DDEPTH`=1. Then `i_XFER`=10 with `i_DOP`=01 also asserted → data TOS is 0xBBBB, `o_DDEPTH`=2, `o_RDEPTH`=0, and the push is ignored.
- **Underflow:** pop on empty return stack → `f_RUNF`=1, `o_RDEPTH`=0. Pulse `i_CLRERR` → `f_RUNF`=0. With data depth 0, `i_XFER`=01 → `f_DUNF`=1 and the return stack is unchanged.
- **Overflow, DEPTH=4:** push 1,2,3,4,5.
  - Without the macro: `o_DDEPTH`=4, `o_TOS`=4, `f_DOVF`=1.
  - With the macro: `o_DDEPTH`=4, `o_TOS`=5, and four pops return 5, 4, 3, 2.
- **Simultaneous ops:** data push 0x0042 and return replace 0x00FF in the same cycle with return depth 1 → both take effect: `o_TOS`=0x0042, `o_RTOS`=0x00FF.
- **Reset mid-stream:** assert `i_RESET` in the same cycle as a push at depth 2 → next cycle `o_DDEPTH`=0, `o_TOS`=0, all flags 0.
